// File: rtl/oclib_pkg.sv
// Shared CSR request/feedback types plus round-robin index helpers used by
// the word-to-CSR bridge family.
package oclib_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
    } csr_32_s;

    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } csr_32_fb_s;

    localparam int DefaultTimeoutCycles = 1024;

    function automatic int rrNext(input int index, input int channels);
        return (index + 1 >= channels) ? 0 : index + 1;
    endfunction

    function automatic int rrWrap(input int base, input int offset, input int channels);
        int sum;
        sum = base + offset;
        return (sum >= channels) ? sum - channels : sum;
    endfunction

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Round-robin selector: picks the first requesting channel at or after the
// rotating pointer, and moves the pointer past the winner when told to.
module oclib_rr_arbiter
    import oclib_pkg::*;
#(
    parameter int  Channels = 2,
    localparam int IdxWidth = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [Channels-1:0] i_request,
    input  logic                i_enable,
    input  logic                i_advance,
    output logic [Channels-1:0] o_grant,
    output logic [IdxWidth-1:0] o_grantIndex
);

    logic [IdxWidth-1:0] r_rrPtr;
    logic                w_found;
    logic [IdxWidth-1:0] w_index;

    always_comb begin
        w_found = 1'b0;
        w_index = '0;
        for (int k = 0; k < Channels; k++) begin
            if (!w_found && i_request[rrWrap(int'(r_rrPtr), k, Channels)]) begin
                w_found = 1'b1;
                w_index = IdxWidth'(rrWrap(int'(r_rrPtr), k, Channels));
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (i_enable && w_found) begin
            o_grant[w_index] = 1'b1;
        end
    end

    assign o_grantIndex = w_index;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rrPtr <= '0;
        end else if (i_advance) begin
            r_rrPtr <= IdxWidth'(rrNext(int'(w_index), Channels));
        end
    end

endmodule

// File: rtl/oclib_words_to_csr_arb.sv
// Several word-request channels share one CSR master port; each request waits
// for target ready or a timeout, and the response goes back to its requester.
module oclib_words_to_csr_arb
    import oclib_pkg::*;
#(
    parameter int  Channels      = 2,
    parameter type CsrType       = oclib_pkg::csr_32_s,
    parameter type CsrFbType     = oclib_pkg::csr_32_fb_s,
    parameter int  TimeoutCycles = DefaultTimeoutCycles,
    parameter int  CountWidth    = 16,
    localparam int IdxWidth      = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  CsrType   [Channels-1:0]    wordInData,
    input  logic     [Channels-1:0]    wordInValid,
    output logic     [Channels-1:0]    wordInReady,
    output CsrFbType [Channels-1:0]    wordOutData,
    output logic     [Channels-1:0]    wordOutValid,
    input  logic     [Channels-1:0]    wordOutReady,
    output CsrType                     csr,
    input  CsrFbType                   csrFb,
    output logic     [CountWidth-1:0]  timeoutCount,
    output logic                       busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]                r_state;
    CsrType                    r_csr;
    logic [IdxWidth-1:0]       r_grantIdx;
    logic [CountWidth-1:0]     r_timer;
    logic [CountWidth-1:0]     r_timeoutCount;
    CsrFbType [Channels-1:0]   r_outData;
    logic [Channels-1:0]       r_outValid;

    logic                      w_idle;
    logic                      w_accept;
    logic                      w_noop;
    logic                      w_timeout;
    logic [Channels-1:0]       w_grant;
    logic [IdxWidth-1:0]       w_grantIdx;
    CsrType                    w_request;
    CsrFbType                  w_noopResp;
    CsrFbType                  w_timeoutResp;

    // Gating with reset keeps ready low while reset is held, even with valids up.
    assign w_idle    = (r_state == StIdle) && !reset;
    assign w_accept  = w_idle && (|wordInValid);
    assign w_request = wordInData[w_grantIdx];
    assign w_noop    = !w_request.read && !w_request.write;
    assign w_timeout = (TimeoutCycles != 0) && (r_timer == CountWidth'(TimeoutCycles - 1));

    oclib_rr_arbiter #(
        .Channels (Channels)
    ) uArbiter (
        .clock        (clock),
        .reset        (reset),
        .i_request    (wordInValid),
        .i_enable     (w_idle),
        .i_advance    (w_accept),
        .o_grant      (w_grant),
        .o_grantIndex (w_grantIdx)
    );

    always_comb begin
        w_noopResp          = '0;
        w_noopResp.ready    = 1'b1;
        w_timeoutResp       = '0;
        w_timeoutResp.ready = 1'b1;
        w_timeoutResp.error = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= StIdle;
            r_csr          <= '0;
            r_grantIdx     <= '0;
            r_timer        <= '0;
            r_timeoutCount <= '0;
            r_outData      <= '0;
            r_outValid     <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_grantIdx <= w_grantIdx;
                        r_timer    <= '0;
                        // A request with neither read nor write never touches the CSR tree.
                        if (w_noop) begin
                            r_outData[w_grantIdx]  <= w_noopResp;
                            r_outValid[w_grantIdx] <= 1'b1;
                            r_state                <= StResp;
                        end else begin
                            r_csr   <= w_request;
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (csrFb.ready) begin
                        r_outData[r_grantIdx]  <= csrFb;
                        r_outValid[r_grantIdx] <= 1'b1;
                        r_csr.read             <= 1'b0;
                        r_csr.write            <= 1'b0;
                        r_state                <= StResp;
                    end else if (w_timeout) begin
                        r_outData[r_grantIdx]  <= w_timeoutResp;
                        r_outValid[r_grantIdx] <= 1'b1;
                        r_csr.read             <= 1'b0;
                        r_csr.write            <= 1'b0;
                        r_state                <= StResp;
                        if (!(&r_timeoutCount)) begin
                            r_timeoutCount <= r_timeoutCount + 1'b1;
                        end
                    end else if (!(&r_timer)) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StResp: begin
                    if (wordOutReady[r_grantIdx]) begin
                        r_outValid[r_grantIdx] <= 1'b0;
                        r_state                <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign wordInReady  = w_grant;
    assign wordOutData  = r_outData;
    assign wordOutValid = r_outValid;
    assign csr          = r_csr;
    assign timeoutCount = r_timeoutCount;
    assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_oclib_words_to_csr_arb.sv
// Directed bench for the two-channel CSR arbiter with an 8-cycle timeout;
// expected values are worked out by hand per scenario.
module tb_oclib_words_to_csr_arb;
    import oclib_pkg::*;

    localparam int Channels = 2;

    logic                        clock = 1'b0;
    logic                        reset;
    csr_32_s    [Channels-1:0]   wordInData;
    logic       [Channels-1:0]   wordInValid;
    logic       [Channels-1:0]   wordInReady;
    csr_32_fb_s [Channels-1:0]   wordOutData;
    logic       [Channels-1:0]   wordOutValid;
    logic       [Channels-1:0]   wordOutReady;
    csr_32_s                     csr;
    csr_32_fb_s                  csrFb;
    logic       [15:0]           timeoutCount;
    logic                        busy;

    int         vectorCount = 0;
    int         missCount   = 0;
    csr_32_fb_s lastResp [Channels];

    oclib_words_to_csr_arb #(
        .Channels      (Channels),
        .TimeoutCycles (8),
        .CountWidth    (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wordInData   (wordInData),
        .wordInValid  (wordInValid),
        .wordInReady  (wordInReady),
        .wordOutData  (wordOutData),
        .wordOutValid (wordOutValid),
        .wordOutReady (wordOutReady),
        .csr          (csr),
        .csrFb        (csrFb),
        .timeoutCount (timeoutCount),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic valid, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        wordInData[ch]  = '{read: rd, write: wr, address: addr, wdata: wdata};
        wordInValid[ch] = valid;
    endtask

    function automatic csr_32_fb_s fb(input logic rdy, input logic err, input logic [31:0] d);
        return '{ready: rdy, error: err, rdata: d};
    endfunction

    function automatic logic [31:0] reqAddr(input int ch, input int n);
        return 32'(32'h100 + ch * 16 + n);
    endfunction

    task automatic doReset();
        reset        = 1'b1;
        wordInValid  = '0;
        wordInData   = '0;
        wordOutReady = '0;
        csrFb        = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int g;
        logic [31:0] addr;
        logic [31:0] rdata;

        reset        = 1'b1;
        wordInData   = '0;
        wordInValid  = 2'b11;
        wordOutReady = '0;
        csrFb        = '0;
        tick();
        tick();

        checkOutput("rst_inReady",  80'(wordInReady),    80'(2'b00));
        checkOutput("rst_outValid", 80'(wordOutValid),   80'(2'b00));
        checkOutput("rst_busy",     80'(busy),           80'(1'b0));
        checkOutput("rst_csr",      80'(csr),            80'(0));
        checkOutput("rst_count",    80'(timeoutCount),   80'(0));
        checkOutput("rst_out0",     80'(wordOutData[0]), 80'(0));
        checkOutput("rst_out1",     80'(wordOutData[1]), 80'(0));

        wordInValid = '0;
        reset       = 1'b0;
        tick();

        // Channel 0 write, target ready on the third write cycle.
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'hA5);
        #1;
        checkOutput("t1_inReady", 80'(wordInReady), 80'(2'b01));
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t1_wr1",   80'(csr.write),   80'(1'b1));
        checkOutput("t1_addr",  80'(csr.address), 80'(32'h10));
        checkOutput("t1_wdata", 80'(csr.wdata),   80'(32'hA5));
        tick();
        checkOutput("t1_wr2", 80'(csr.write), 80'(1'b1));
        tick();
        checkOutput("t1_wr3", 80'(csr.write), 80'(1'b1));
        csrFb = fb(1'b1, 1'b0, 32'h0);
        tick();
        csrFb = '0;
        checkOutput("t1_wrDrop",  80'(csr.write),      80'(1'b0));
        checkOutput("t1_outValid",80'(wordOutValid),   80'(2'b01));
        checkOutput("t1_resp0",   80'(wordOutData[0]), 80'(fb(1'b1, 1'b0, 32'h0)));
        checkOutput("t1_out1",    80'(wordOutData[1]), 80'(0));
        wordOutReady = 2'b01;
        tick();
        wordOutReady = 2'b00;
        checkOutput("t1_validClr", 80'(wordOutValid), 80'(2'b00));
        checkOutput("t1_idle",     80'(busy),         80'(1'b0));

        // Both channels streaming reads; grants must alternate from channel 0.
        doReset();
        lastResp[0]  = '0;
        lastResp[1]  = '0;
        wordOutReady = 2'b11;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, reqAddr(0, 0), 32'h0);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, reqAddr(1, 0), 32'h0);
        #1;
        for (int t = 0; t < 8; t++) begin
            g     = t % 2;
            addr  = reqAddr(g, t / 2);
            rdata = 32'hD000_0000 | addr;
            checkOutput($sformatf("t2_grant%0d", t), 80'(wordInReady), 80'(1 << g));
            tick();
            if (t / 2 < 3) begin
                applyStimulus(g, 1'b1, 1'b1, 1'b0, reqAddr(g, t / 2 + 1), 32'h0);
            end else begin
                applyStimulus(g, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            checkOutput($sformatf("t2_read%0d", t), 80'(csr.read),    80'(1'b1));
            checkOutput($sformatf("t2_addr%0d", t), 80'(csr.address), 80'(addr));
            tick();
            csrFb = fb(1'b1, 1'b0, rdata);
            tick();
            csrFb = '0;
            checkOutput($sformatf("t2_valid%0d", t), 80'(wordOutValid),       80'(1 << g));
            checkOutput($sformatf("t2_resp%0d", t),  80'(wordOutData[g]),     80'(fb(1'b1, 1'b0, rdata)));
            checkOutput($sformatf("t2_other%0d", t), 80'(wordOutData[1 - g]), 80'(lastResp[1 - g]));
            lastResp[g] = fb(1'b1, 1'b0, rdata);
            tick();
        end
        wordOutReady = 2'b00;

        // Target never answers: timeout after 8 cycles in the wait state.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'hDEAD0, 32'h0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (7) tick();
        checkOutput("t3_stillBusy",  80'(busy),         80'(1'b1));
        checkOutput("t3_noValidYet", 80'(wordOutValid), 80'(2'b00));
        checkOutput("t3_readHeld",   80'(csr.read),     80'(1'b1));
        tick();
        checkOutput("t3_valid",  80'(wordOutValid),   80'(2'b01));
        checkOutput("t3_resp",   80'(wordOutData[0]), 80'(fb(1'b1, 1'b1, 32'h0)));
        checkOutput("t3_count",  80'(timeoutCount),   80'(16'd1));
        checkOutput("t3_rdDrop", 80'(csr.read),       80'(1'b0));
        wordOutReady = 2'b01;
        tick();
        wordOutReady = 2'b00;

        // Ready arrives on the very cycle the timeout would fire; ready wins.
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (7) tick();
        csrFb = fb(1'b1, 1'b0, 32'h1234_5678);
        tick();
        csrFb = '0;
        checkOutput("t4_valid", 80'(wordOutValid),   80'(2'b01));
        checkOutput("t4_resp",  80'(wordOutData[0]), 80'(fb(1'b1, 1'b0, 32'h1234_5678)));
        checkOutput("t4_count", 80'(timeoutCount),   80'(16'd1));
        wordOutReady = 2'b01;
        tick();
        wordOutReady = 2'b00;

        // Channel 1 response held back while channel 0 waits to be granted.
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        csrFb = fb(1'b1, 1'b0, 32'hBEEF);
        tick();
        csrFb = '0;
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h77);
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_valid%0d", i),   80'(wordOutValid),   80'(2'b10));
            checkOutput($sformatf("t5_data%0d", i),    80'(wordOutData[1]), 80'(fb(1'b1, 1'b0, 32'hBEEF)));
            checkOutput($sformatf("t5_inReady%0d", i), 80'(wordInReady),    80'(2'b00));
            tick();
        end
        wordOutReady = 2'b10;
        tick();
        wordOutReady = 2'b00;
        checkOutput("t5_ch0Grant", 80'(wordInReady),  80'(2'b01));
        checkOutput("t5_validClr", 80'(wordOutValid), 80'(2'b00));
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t5_write", 80'(csr.write),   80'(1'b1));
        checkOutput("t5_addr",  80'(csr.address), 80'(32'h40));

        // Reset lands mid-wait; outputs must drop without waiting for a clock.
        tick();
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h99);
        reset = 1'b1;
        #1;
        checkOutput("t6_write",    80'(csr.write),    80'(1'b0));
        checkOutput("t6_read",     80'(csr.read),     80'(1'b0));
        checkOutput("t6_inReady",  80'(wordInReady),  80'(2'b00));
        checkOutput("t6_outValid", 80'(wordOutValid), 80'(2'b00));
        checkOutput("t6_busy",     80'(busy),         80'(1'b0));
        tick();
        reset = 1'b0;
        #1;
        checkOutput("t6_freshGrant", 80'(wordInReady),  80'(2'b10));
        checkOutput("t6_noResp",     80'(wordOutValid), 80'(2'b00));
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("t6_wr",   80'(csr.write),   80'(1'b1));
        checkOutput("t6_addr", 80'(csr.address), 80'(32'h50));
        tick();
        csrFb = fb(1'b1, 1'b0, 32'h5A5A);
        tick();
        csrFb = '0;
        checkOutput("t6_valid", 80'(wordOutValid),   80'(2'b10));
        checkOutput("t6_resp",  80'(wordOutData[1]), 80'(fb(1'b1, 1'b0, 32'h5A5A)));
        wordOutReady = 2'b10;
        tick();
        wordOutReady = 2'b00;
        checkOutput("t6_done", 80'(busy), 80'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/oclib_words_to_csr_arb.md
Name: oclib_words_to_csr_arb

Overview:
Multi-channel successor to the single-channel words-to-CSR bridge. Channels word-request ports share one CSR master port through a round-robin arbiter. Each request stays outstanding until the CSR target returns csrFb.ready or a programmable timeout expires; a timeout produces an error response. The response returns only to the originating channel. The block sits between several host or debug word streams and one CSR tree.

Parameters:
Channels, 2, number of word-request channels (1..16)
CsrType, oclib_pkg::csr_32_s, request struct (has read, write, address, wdata fields)
CsrFbType, oclib_pkg::csr_32_fb_s, response struct (has ready, error, rdata fields)
TimeoutCycles, 1024, cycles in StWait before a forced error response; 0 disables the timeout
CountWidth, 16, width of the saturating timeout counter

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high; all state clears immediately
wordInData  in  Channels x $bits(CsrType)  per-channel request word
wordInValid  in  Channels  per-channel request valid
wordInReady  out  Channels  per-channel request ready; at most one bit high
wordOutData  out  Channels x $bits(CsrFbType)  per-channel response word
wordOutValid  out  Channels  per-channel response valid; at most one bit high
wordOutReady  in  Channels  per-channel response ready
csr  out  $bits(CsrType)  CSR request to the target
csrFb  in  $bits(CsrFbType)  CSR feedback from the target
timeoutCount  out  CountWidth  number of timeouts seen, saturating
busy  out  1  high whenever the state is not StIdle

Behaviour:
- Reset values:
  - wordInReady, wordOutValid, busy, csr (entire struct): 0.
  - wordOutData: all 0.
  - timeoutCount: 0.
  - rrPtr, grant index, timer: 0. State is StIdle.
- Arbitration (StIdle):
  - The grant goes to the lowest-index channel with wordInValid set, searching from rrPtr with wrap-around.
  - wordInReady[grant] is combinational and is high only in StIdle, only when some valid bit is set.
  - On accept: capture the request into the csr register, latch the grant index, set rrPtr = (grant+1) mod Channels, clear the timer, move to StWait.
- StWait:
  - csr holds the captured request; csr.read and csr.write are asserted from the cycle after accept, which is 1-cycle latency.
  - The timer increments each cycle.
  - If csrFb.ready: register csrFb into wordOutData[grant], drop csr.read and csr.write, assert wordOutValid[grant] next cycle, move to StResp.
  - Otherwise, if TimeoutCycles != 0 and the timer reaches TimeoutCycles-1:
    - the response is ready=1, error=1, rdata=0;
    - drop read and write;
    - timeoutCount increments, saturating at all-ones;
    - move to StResp.
  - If csrFb.ready and the timeout occur in the same cycle, ready wins and there is no error or count.
- No-op request (read=0 and write=0): skip the CSR port entirely. The response is ready=1, error=0, rdata=0, entering StResp the cycle after accept.
- StResp:
  - Hold wordOutValid[grant] and the data until wordOutReady[grant]; then clear valid and return to StIdle.
  - The next accept can occur no earlier than the cycle after the handshake.
- csrFb.ready outside StWait is ignored; wordOutData does not change.
- wordOutData is updated only for the granted channel. The other channels keep their last response.
- Reset asserted mid-transaction: csr.read and csr.write drop asynchronously, the response is lost, and no partial handshake occurs after reset releases.
- Channels=1 degenerates to single-channel behaviour with timeout added.

Decomposition:
- Package oclib_pkg holds the existing CSR typedefs. Add a localparam for the default timeout and a function for the round-robin next index if the package does not already have one.
- Sub-module oclib_rr_arbiter handles round-robin selection:
  - Parameter Channels.
  - Inputs: request vector, enable, advance.
  - Outputs: one-hot grant, grant index.
  - It owns rrPtr.

Test Plan:
- Channel 0 issues a write to 0x10 with wdata 0xA5; the target gives ready 3 cycles later. Required: csr.write is high for exactly 3 cycles, wordOutValid[0] is asserted the next cycle, and the channel 1 outputs do not change.
- Both channels are valid continuously, issuing 4 reads each, with the target ready 1 cycle after each request. Required: grants alternate 0,1,0,1,... and each response rdata reaches only its requester.
- Read to an unmapped address with the target never ready and TimeoutCycles=8. Required: the response has error=1 and rdata=0 after 8 cycles in StWait, and timeoutCount goes from 0 to 1.
- csrFb.ready coincides with the final timeout cycle. Required: error=0, the response carries the target's rdata, and timeoutCount is unchanged.
- Hold wordOutReady[1] low for 5 cycles with channel 0 valid. Required: wordOutValid[1] and its data stay stable, wordInReady stays 0, and channel 0 is granted the cycle after the response handshake.
- Assert reset during StWait. Required: csr.read goes to 0 immediately (asynchronously) and all valids and readies are 0. After release, a fresh request completes normally.
